fft_bfly_sched: RTL and testbench
=================================

Name: fft_bfly_sched

Overview:
- Sequences one in-place radix-2 DIT FFT over the shared dual-port sample RAM.
- Generates per-butterfly top/bottom addresses and twiddle index, issued to the butterfly datapath over a valid/ready handshake.
- Counts outstanding butterflies so stage s+1 never reads a location before stage s has written it back.
- Sits between the top-level control FSM (Start/Ack/Done) and the butterfly unit plus RAM port muxing.

Parameters:
- LOG2N, 8, log2 of transform length; N = 2^LOG2N points, N/2 butterflies per stage, LOG2N stages.
- MAX_OUT, 4, maximum butterflies in flight; issue stalls while outstanding == MAX_OUT.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- Ack  in  1  acknowledges Done; sampled only in DONE.
- BflyReady  in  1  butterfly unit accepts the current issue this cycle.
- WbValid  in  1  butterfly unit has written back one result pair to RAM this cycle.
- BflyValid  out  1  i_top/i_bot/TwIdx hold a valid butterfly.
- i_top  out  LOG2N  RAM address of the top input/output.
- i_bot  out  LOG2N  RAM address of the bottom input/output.
- TwIdx  out  LOG2N-1  twiddle ROM index k for W_N^k.
- Stage  out  log2(LOG2N)+1  current stage number, 0..LOG2N-1.
- Busy  out  1  high in ISSUE and DRAIN.
- Done  out  1  high in DONE.
- Error  out  1  sticky; set on WbValid while outstanding == 0; cleared only by reset.

Behaviour:
- Reset (Reset_n=0 at a clock edge): state=IDLE, stage=0, b=0, outstanding=0. All outputs 0, including Error. Reset mid-transform aborts immediately; no draining.
- States: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE: Start=1 -> ISSUE with stage=0, b=0. Start is ignored in every other state.
- ISSUE: BflyValid=1 unless outstanding == MAX_OUT.
  - Fire = BflyValid & BflyReady.
  - Addresses and TwIdx stay stable while BflyValid=1 and BflyReady=0.
  - On fire with b < N/2-1: b increments; the next address is presented the following cycle, giving back-to-back issue.
  - On fire with b == N/2-1: -> DRAIN, BflyValid=0.
- Address generation for stage s, butterfly b, with half = 2^s:
  - pos = b mod half; grp = b >> s.
  - i_top = grp*2*half + pos.
  - i_bot = i_top + half.
  - TwIdx = pos << (LOG2N-1-s).
  - All arithmetic is unsigned and LOG2N bits wide; no overflow is possible by construction.
- Outstanding counter: +1 on fire, -1 on WbValid. Fire and WbValid in the same cycle leave it unchanged. WbValid with outstanding == 0 sets Error and leaves the counter at 0.
- DRAIN: waits for outstanding == 0.
  - If stage < LOG2N-1: stage++, b=0, -> ISSUE.
  - If stage == LOG2N-1: -> DONE.
  - If the last write-back arrives in the same cycle DRAIN is entered, the exit is taken on the next cycle.
- DONE: Done=1, Busy=0. Ack=1 -> IDLE, with Done=0 the next cycle and stage cleared to 0.
- Latency with BflyReady tied high and a write-back L cycles after issue: per stage N/2 issue cycles plus L+1 drain cycles, plus one DONE entry cycle.

Test Plan:
- LOG2N=3, BflyReady=1, WbValid 2 cycles after each fire, pulse Start -> issued (i_top,i_bot,TwIdx) in order:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - then Done=1, and Done=0 one cycle after Ack.
- Hold BflyReady=0 for 3 cycles during stage-1 butterfly 1 -> BflyValid stays 1 and outputs hold (1,3,2) unchanged; advances the cycle after BflyReady rises.
- MAX_OUT=2 with no WbValid -> exactly 2 fires, then BflyValid=0. One WbValid -> one more fire. Stage 1 does not start until outstanding reaches 0.
- Fire and WbValid in the same cycle with outstanding=1 -> outstanding stays 1. A spurious WbValid in IDLE -> Error=1, held until reset.
- Deassert Reset_n in the middle of stage 1 -> next cycle state=IDLE and all outputs 0. A subsequent Start re-runs from stage 0, b=0.
- Pulse Start during ISSUE or DONE -> no effect on the sequence; Ack pulsed outside DONE -> no effect.

Source files
------------

// File: rtl/fft_bfly_sched_if.sv
// Butterfly scheduler bus: control handshake (Start/Ack/Done), butterfly
// issue handshake and write-back notification, grouped for port connection.
interface fft_bfly_sched_if #(
  parameter int LOG2N = 8
) ();
  localparam int SW = $clog2(LOG2N) + 1;

  logic             Start;
  logic             Ack;
  logic             BflyReady;
  logic             WbValid;
  logic             BflyValid;
  logic [LOG2N-1:0] i_top;
  logic [LOG2N-1:0] i_bot;
  logic [LOG2N-2:0] TwIdx;
  logic [SW-1:0]    Stage;
  logic             Busy;
  logic             Done;
  logic             Error;

  // Scheduler side: issues butterflies and reports status
  modport master (
    input  Start, Ack, BflyReady, WbValid,
    output BflyValid, i_top, i_bot, TwIdx, Stage, Busy, Done, Error
  );

  // Environment side: control FSM plus butterfly unit
  modport slave (
    output Start, Ack, BflyReady, WbValid,
    input  BflyValid, i_top, i_bot, TwIdx, Stage, Busy, Done, Error
  );
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT butterfly scheduler. Walks LOG2N stages of N/2
// butterflies, issuing top/bottom RAM addresses and twiddle index, and holds
// back the next stage until every write-back of the current one has landed.
module fft_bfly_sched #(
  parameter int LOG2N   = 8,
  parameter int MAX_OUT = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  fft_bfly_sched_if.master bus
);
  localparam int SW = $clog2(LOG2N) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  localparam logic [SW-1:0]    STAGE_ZERO = '0;
  localparam logic [SW-1:0]    STAGE_ONE  = SW'(1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] B_ZERO     = '0;
  localparam logic [LOG2N-2:0] B_ONE      = (LOG2N - 1)'(1);
  localparam logic [LOG2N-2:0] B_LAST     = '1;
  localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);
  localparam logic [OW-1:0]    OUT_ZERO   = '0;
  localparam logic [OW-1:0]    OUT_ONE    = OW'(1);
  localparam logic [OW-1:0]    OUT_MAX    = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_stage;
  logic [LOG2N-2:0] r_b;
  logic [OW-1:0]    r_out;
  logic             r_valid;
  logic [LOG2N-1:0] r_top;
  logic [LOG2N-1:0] r_bot;
  logic [LOG2N-2:0] r_tw;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_fire;
  logic             w_wbDec;
  logic             w_wbErr;
  logic [OW-1:0]    w_outNext;
  logic             w_validNext;

  // Butterfly span for stage s: 2^s
  function automatic logic [LOG2N-1:0] halfOf(input logic [SW-1:0] s);
    return A_ONE << s;
  endfunction

  // Position of butterfly b inside its group
  function automatic logic [LOG2N-1:0] posOf(input logic [SW-1:0] s,
                                             input logic [LOG2N-2:0] b);
    logic [LOG2N-1:0] bw;
    bw = {1'b0, b};
    return bw & (halfOf(s) - A_ONE);
  endfunction

  // Top address: group base (grp * 2 * half) plus position
  function automatic logic [LOG2N-1:0] topOf(input logic [SW-1:0] s,
                                             input logic [LOG2N-2:0] b);
    logic [LOG2N-1:0] bw;
    logic [LOG2N-1:0] grp;
    bw  = {1'b0, b};
    grp = bw >> s;
    return ((grp << s) << 1) | posOf(s, b);
  endfunction

  function automatic logic [LOG2N-1:0] botOf(input logic [SW-1:0] s,
                                             input logic [LOG2N-2:0] b);
    return topOf(s, b) + halfOf(s);
  endfunction

  // Twiddle index: position scaled so stage s uses every 2^(LOG2N-1-s)th root
  function automatic logic [LOG2N-2:0] twOf(input logic [SW-1:0] s,
                                            input logic [LOG2N-2:0] b);
    logic [LOG2N-1:0] full;
    full = posOf(s, b) << (STAGE_LAST - s);
    return full[LOG2N-2:0];
  endfunction

  assign w_fire  = r_valid & bus.BflyReady;
  assign w_wbDec = bus.WbValid & (r_out != OUT_ZERO);
  assign w_wbErr = bus.WbValid & (r_out == OUT_ZERO);

  // Next outstanding count; a spurious write-back never underflows it
  always_comb begin
    w_outNext = r_out;
    case ({w_fire, w_wbDec})
      2'b10:   w_outNext = r_out + OUT_ONE;
      2'b01:   w_outNext = r_out - OUT_ONE;
      default: w_outNext = r_out;
    endcase
    w_validNext = (w_outNext != OUT_MAX);
  end

  // Scheduler FSM with registered outputs and in-flight tracking
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_stage <= STAGE_ZERO;
      r_b     <= B_ZERO;
      r_out   <= OUT_ZERO;
      r_valid <= 1'b0;
      r_top   <= '0;
      r_bot   <= '0;
      r_tw    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_out <= w_outNext;
      if (w_wbErr) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_state <= S_ISSUE;
            r_stage <= STAGE_ZERO;
            r_b     <= B_ZERO;
            r_busy  <= 1'b1;
            r_valid <= w_validNext;
            r_top   <= topOf(STAGE_ZERO, B_ZERO);
            r_bot   <= botOf(STAGE_ZERO, B_ZERO);
            r_tw    <= twOf(STAGE_ZERO, B_ZERO);
          end
        end
        S_ISSUE: begin
          r_valid <= w_validNext;
          if (w_fire) begin
            if (r_b == B_LAST) begin
              r_state <= S_DRAIN;
              r_valid <= 1'b0;
            end else begin
              r_b   <= r_b + B_ONE;
              r_top <= topOf(r_stage, r_b + B_ONE);
              r_bot <= botOf(r_stage, r_b + B_ONE);
              r_tw  <= twOf(r_stage, r_b + B_ONE);
            end
          end
        end
        S_DRAIN: begin
          if (r_out == OUT_ZERO) begin
            if (r_stage == STAGE_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_stage <= r_stage + STAGE_ONE;
              r_b     <= B_ZERO;
              r_valid <= w_validNext;
              r_top   <= topOf(r_stage + STAGE_ONE, B_ZERO);
              r_bot   <= botOf(r_stage + STAGE_ONE, B_ZERO);
              r_tw    <= twOf(r_stage + STAGE_ONE, B_ZERO);
            end
          end
        end
        S_DONE: begin
          if (bus.Ack) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_stage <= STAGE_ZERO;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BflyValid = r_valid;
  assign bus.i_top     = r_top;
  assign bus.i_bot     = r_bot;
  assign bus.TwIdx     = r_tw;
  assign bus.Stage     = r_stage;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Error     = r_err;
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched with an 8-point transform. Instance A
// allows 4 butterflies in flight, instance B only 2 to exercise stalling.
module tb_fft_bfly_sched;
  localparam int LOG2N = 3;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  fft_bfly_sched_if #(.LOG2N(LOG2N)) busA ();
  fft_bfly_sched_if #(.LOG2N(LOG2N)) busB ();

  fft_bfly_sched #(.LOG2N(LOG2N), .MAX_OUT(4)) dutA (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (busA)
  );

  fft_bfly_sched #(.LOG2N(LOG2N), .MAX_OUT(2)) dutB (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (busB)
  );

  always #5 Clk = ~Clk;

  int checkCount = 0;
  int errorCount = 0;

  // Hand-derived issue order for N=8
  int expTop[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int expBot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int expTw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic [1:0] pipeA;
  bit wbModelOn;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One cycle on A with a write-back returned 2 cycles after each fire
  task automatic tickA();
    logic f;
    busA.WbValid = wbModelOn ? pipeA[1] : 1'b0;
    f = busA.BflyValid & busA.BflyReady;
    tick();
    pipeA[1] = pipeA[0];
    pipeA[0] = f;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    busA.Start = 1'b0; busA.Ack = 1'b0; busA.BflyReady = 1'b0; busA.WbValid = 1'b0;
    busB.Start = 1'b0; busB.Ack = 1'b0; busB.BflyReady = 1'b0; busB.WbValid = 1'b0;
    pipeA = 2'b00;
    wbModelOn = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    Reset_n = 1'b0;
    tick();
    if (busA.BflyValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_valid got %0b expected 0", busA.BflyValid); end
    checkCount++;
    if (busA.i_top !== 3'd0) begin errorCount++; $display("[TB] FAIL reset_top got %0d expected 0", busA.i_top); end
    checkCount++;
    if (busA.i_bot !== 3'd0) begin errorCount++; $display("[TB] FAIL reset_bot got %0d expected 0", busA.i_bot); end
    checkCount++;
    if (busA.TwIdx !== 2'd0) begin errorCount++; $display("[TB] FAIL reset_tw got %0d expected 0", busA.TwIdx); end
    checkCount++;
    if (busA.Stage !== 3'd0) begin errorCount++; $display("[TB] FAIL reset_stage got %0d expected 0", busA.Stage); end
    checkCount++;
    if (busA.Busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got %0b expected 0", busA.Busy); end
    checkCount++;
    if (busA.Done !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_done got %0b expected 0", busA.Done); end
    checkCount++;
    if (busA.Error !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_error got %0b expected 0", busA.Error); end
    checkCount++;
    Reset_n = 1'b1;
  endtask

  // Full transform on A; optional stall at issue holdIdx and stray Start/Ack pulses
  task automatic runTransform(input int holdIdx, input bit pulseOthers, input int expDone);
    int cyc;
    int idx;
    int hold;
    bit seen;
    doReset();
    wbModelOn = 1'b1;
    busA.BflyReady = 1'b1;
    busA.Start = 1'b1;
    tickA();
    busA.Start = 1'b0;
    cyc = 1; idx = 0; hold = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      busA.Start = pulseOthers && (cyc == 3);
      busA.Ack   = pulseOthers && (cyc == 10);
      if (busA.Done === 1'b1) begin
        seen = 1'b1;
      end else begin
        busA.BflyReady = 1'b1;
        if (busA.BflyValid === 1'b1) begin
          if (idx >= 12) begin
            errorCount++; $display("[TB] FAIL extra_issue got index %0d expected at most 11", idx);
            checkCount++;
          end else begin
            if (idx == holdIdx && hold < 3) begin
              busA.BflyReady = 1'b0;
              hold++;
            end
            if (busA.i_top !== 3'(expTop[idx])) begin errorCount++; $display("[TB] FAIL top[%0d] got %0d expected %0d", idx, busA.i_top, expTop[idx]); end
            checkCount++;
            if (busA.i_bot !== 3'(expBot[idx])) begin errorCount++; $display("[TB] FAIL bot[%0d] got %0d expected %0d", idx, busA.i_bot, expBot[idx]); end
            checkCount++;
            if (busA.TwIdx !== 2'(expTw[idx])) begin errorCount++; $display("[TB] FAIL tw[%0d] got %0d expected %0d", idx, busA.TwIdx, expTw[idx]); end
            checkCount++;
            if (busA.Stage !== 3'(idx / 4)) begin errorCount++; $display("[TB] FAIL stage[%0d] got %0d expected %0d", idx, busA.Stage, idx / 4); end
            checkCount++;
            if (busA.BflyReady === 1'b1) idx++;
          end
        end
        tickA();
        cyc++;
      end
    end
    busA.Start = 1'b0;
    busA.Ack = 1'b0;
    if (seen !== 1'b1) begin errorCount++; $display("[TB] FAIL done_timeout got no Done expected Done within 200 cycles"); end
    checkCount++;
    if (cyc != expDone) begin errorCount++; $display("[TB] FAIL done_latency got %0d expected %0d", cyc, expDone); end
    checkCount++;
    if (idx != 12) begin errorCount++; $display("[TB] FAIL issue_count got %0d expected 12", idx); end
    checkCount++;
    if (busA.Busy !== 1'b0) begin errorCount++; $display("[TB] FAIL done_busy got %0b expected 0", busA.Busy); end
    checkCount++;
    if (busA.Stage !== 3'd2) begin errorCount++; $display("[TB] FAIL done_stage got %0d expected 2", busA.Stage); end
    checkCount++;
    if (pulseOthers) begin
      busA.Start = 1'b1;
      tickA();
      busA.Start = 1'b0;
      if (busA.Done !== 1'b1) begin errorCount++; $display("[TB] FAIL start_in_done got Done=%0b expected 1", busA.Done); end
      checkCount++;
    end
    busA.Ack = 1'b1;
    tickA();
    busA.Ack = 1'b0;
    if (busA.Done !== 1'b0) begin errorCount++; $display("[TB] FAIL ack_done got %0b expected 0", busA.Done); end
    checkCount++;
    if (busA.Stage !== 3'd0) begin errorCount++; $display("[TB] FAIL ack_stage got %0d expected 0", busA.Stage); end
    checkCount++;
    tickA();
    if (busA.Busy !== 1'b0 || busA.BflyValid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL idle_after_ack got busy=%0b valid=%0b expected 0 0", busA.Busy, busA.BflyValid);
    end
    checkCount++;
    if (busA.Error !== 1'b0) begin errorCount++; $display("[TB] FAIL transform_error got %0b expected 0", busA.Error); end
    checkCount++;
  endtask

  task automatic test_full_transform();
    runTransform(-1, 1'b1, 22);
  endtask

  task automatic test_backpressure();
    runTransform(5, 1'b0, 25);
  endtask

  task automatic test_max_out();
    int fires;
    doReset();
    busB.BflyReady = 1'b1;
    busB.Start = 1'b1;
    tick();
    busB.Start = 1'b0;
    fires = 0;
    repeat (6) begin
      if (busB.BflyValid === 1'b1) fires++;
      tick();
    end
    if (fires != 2) begin errorCount++; $display("[TB] FAIL maxout_fires got %0d expected 2", fires); end
    checkCount++;
    if (busB.BflyValid !== 1'b0) begin errorCount++; $display("[TB] FAIL maxout_stall got %0b expected 0", busB.BflyValid); end
    checkCount++;
    for (int p = 0; p < 2; p++) begin
      fires = 0;
      busB.WbValid = 1'b1;
      if (busB.BflyValid === 1'b1) fires++;
      tick();
      busB.WbValid = 1'b0;
      repeat (4) begin
        if (busB.BflyValid === 1'b1) fires++;
        tick();
      end
      if (fires != 1) begin errorCount++; $display("[TB] FAIL maxout_refire%0d got %0d expected 1", p, fires); end
      checkCount++;
    end
    if (busB.Busy !== 1'b1 || busB.BflyValid !== 1'b0 || busB.Stage !== 3'd0) begin
      errorCount++; $display("[TB] FAIL drain_state got busy=%0b valid=%0b stage=%0d expected 1 0 0", busB.Busy, busB.BflyValid, busB.Stage);
    end
    checkCount++;
    busB.WbValid = 1'b1;
    tick();
    busB.WbValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (busB.Stage !== 3'd0 || busB.BflyValid !== 1'b0) begin
        errorCount++; $display("[TB] FAIL drain_hold%0d got stage=%0d valid=%0b expected 0 0", k, busB.Stage, busB.BflyValid);
      end
      checkCount++;
      tick();
    end
    busB.WbValid = 1'b1;
    tick();
    busB.WbValid = 1'b0;
    if (busB.Stage !== 3'd0) begin errorCount++; $display("[TB] FAIL drain_exit_delay got stage=%0d expected 0", busB.Stage); end
    checkCount++;
    tick();
    if (busB.Stage !== 3'd1 || busB.BflyValid !== 1'b1) begin
      errorCount++; $display("[TB] FAIL stage1_start got stage=%0d valid=%0b expected 1 1", busB.Stage, busB.BflyValid);
    end
    checkCount++;
    if (busB.i_top !== 3'd0 || busB.i_bot !== 3'd2) begin
      errorCount++; $display("[TB] FAIL stage1_addr got %0d,%0d expected 0,2", busB.i_top, busB.i_bot);
    end
    checkCount++;
  endtask

  task automatic test_same_cycle();
    doReset();
    busB.BflyReady = 1'b1;
    busB.Start = 1'b1;
    tick();
    busB.Start = 1'b0;
    if (busB.BflyValid !== 1'b1) begin errorCount++; $display("[TB] FAIL same_first got %0b expected 1", busB.BflyValid); end
    checkCount++;
    tick();
    if (busB.BflyValid !== 1'b1) begin errorCount++; $display("[TB] FAIL same_second got %0b expected 1", busB.BflyValid); end
    checkCount++;
    busB.WbValid = 1'b1;
    tick();
    busB.WbValid = 1'b0;
    if (busB.BflyValid !== 1'b1) begin errorCount++; $display("[TB] FAIL same_after got %0b expected 1", busB.BflyValid); end
    checkCount++;
    tick();
    if (busB.BflyValid !== 1'b0) begin errorCount++; $display("[TB] FAIL same_full got %0b expected 0", busB.BflyValid); end
    checkCount++;
    if (busB.Error !== 1'b0) begin errorCount++; $display("[TB] FAIL same_error got %0b expected 0", busB.Error); end
    checkCount++;
  endtask

  task automatic test_spurious_wb();
    doReset();
    busA.WbValid = 1'b1;
    tick();
    busA.WbValid = 1'b0;
    if (busA.Error !== 1'b1) begin errorCount++; $display("[TB] FAIL spurious_set got %0b expected 1", busA.Error); end
    checkCount++;
    repeat (3) tick();
    if (busA.Error !== 1'b1 || busA.Busy !== 1'b0) begin
      errorCount++; $display("[TB] FAIL spurious_sticky got err=%0b busy=%0b expected 1 0", busA.Error, busA.Busy);
    end
    checkCount++;
    doReset();
    if (busA.Error !== 1'b0) begin errorCount++; $display("[TB] FAIL spurious_clear got %0b expected 0", busA.Error); end
    checkCount++;
  endtask

  task automatic test_reset_mid();
    int s1;
    int guard;
    doReset();
    wbModelOn = 1'b1;
    busA.BflyReady = 1'b1;
    busA.Start = 1'b1;
    tickA();
    busA.Start = 1'b0;
    s1 = 0;
    guard = 0;
    while (s1 < 2 && guard < 100) begin
      if (busA.BflyValid === 1'b1 && busA.Stage === 3'd1) s1++;
      tickA();
      guard++;
    end
    if (s1 != 2) begin errorCount++; $display("[TB] FAIL midreset_reach got %0d stage1 fires expected 2", s1); end
    checkCount++;
    Reset_n = 1'b0;
    wbModelOn = 1'b0;
    pipeA = 2'b00;
    busA.WbValid = 1'b0;
    tick();
    if (busA.BflyValid !== 1'b0 || busA.i_top !== 3'd0 || busA.i_bot !== 3'd0 || busA.TwIdx !== 2'd0) begin
      errorCount++; $display("[TB] FAIL midreset_issue got v=%0b t=%0d b=%0d w=%0d expected all 0", busA.BflyValid, busA.i_top, busA.i_bot, busA.TwIdx);
    end
    checkCount++;
    if (busA.Stage !== 3'd0 || busA.Busy !== 1'b0 || busA.Done !== 1'b0 || busA.Error !== 1'b0) begin
      errorCount++; $display("[TB] FAIL midreset_status got s=%0d busy=%0b done=%0b err=%0b expected all 0", busA.Stage, busA.Busy, busA.Done, busA.Error);
    end
    checkCount++;
    Reset_n = 1'b1;
    wbModelOn = 1'b1;
    busA.Start = 1'b1;
    tickA();
    busA.Start = 1'b0;
    if (busA.BflyValid !== 1'b1 || busA.Stage !== 3'd0 || busA.i_top !== 3'd0 || busA.i_bot !== 3'd1 || busA.TwIdx !== 2'd0) begin
      errorCount++; $display("[TB] FAIL restart got v=%0b s=%0d t=%0d b=%0d w=%0d expected 1 0 0 1 0", busA.BflyValid, busA.Stage, busA.i_top, busA.i_bot, busA.TwIdx);
    end
    checkCount++;
  endtask

  initial begin
    busA.Start = 1'b0; busA.Ack = 1'b0; busA.BflyReady = 1'b0; busA.WbValid = 1'b0;
    busB.Start = 1'b0; busB.Ack = 1'b0; busB.BflyReady = 1'b0; busB.WbValid = 1'b0;
    pipeA = 2'b00;
    wbModelOn = 1'b0;
    test_reset();
    test_full_transform();
    test_backpressure();
    test_max_out();
    test_same_cycle();
    test_spurious_wb();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
